// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and constants for the IF-stage fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Instruction loaded into IF/ID when it is flushed (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count enabled cycles, holding once the counter is full
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : IF-stage sequencing controller. Arbitrates EX redirects,
//               decode load-use stalls and imem wait states, driving the PC
//               enable/mux and the IF/ID enable/flush. Holds one pending
//               redirect target and three saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_sel_ex,
    input  logic [31:0]      pc_ex,
    input  logic             stall_dec,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             pc_en,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             if_en,
    output logic             if_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    state_t      r_state;
    logic [31:0] r_redirect_q;

    state_t      w_state;
    state_t      w_next_state;
    logic        w_load_rq;
    logic        w_stall_inc;
    logic        w_flush_inc;
    logic        w_wait_inc;

    // While reset is held the outputs decode as IDLE regardless of the state
    // register, so the datapath sees a quiet fetch stage immediately.
    assign w_state = rst ? IDLE : r_state;

    // Mealy decode of the datapath controls, next state and counter strobes.
    // imem_req depends on state only, keeping imem_ready out of its cone.
    always_comb begin
        imem_req     = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 1'b0;
        pc_target    = r_redirect_q;
        if_en        = 1'b1;
        if_flush     = 1'b1;
        w_next_state = r_state;
        w_load_rq    = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_wait_inc   = 1'b0;

        case (w_state)
            IDLE: begin
                pc_target    = RESET_PC;
                w_next_state = RUN;
            end

            RUN: begin
                imem_req   = 1'b1;
                // Every fetching cycle without a returned instruction is a wait
                w_wait_inc = ~imem_ready;
                if (pc_sel_ex) begin
                    w_flush_inc = 1'b1;
                    if (imem_ready) begin
                        pc_en     = 1'b1;
                        pc_sel    = 1'b1;
                        pc_target = pc_ex;
                    end else begin
                        // Fetch still in flight for the wrong path: remember
                        // the target and drop the returning instruction.
                        w_load_rq    = 1'b1;
                        w_next_state = DISCARD;
                    end
                end else if (stall_dec) begin
                    if_en       = 1'b0;
                    if_flush    = 1'b0;
                    w_stall_inc = 1'b1;
                end else if (imem_ready) begin
                    pc_en    = 1'b1;
                    if_flush = 1'b0;
                end
            end

            DISCARD: begin
                imem_req   = 1'b1;
                w_wait_inc = ~imem_ready;
                if (pc_sel_ex) begin
                    // Newest redirect supersedes the pending one
                    w_load_rq   = 1'b1;
                    w_flush_inc = 1'b1;
                end
                if (imem_ready) begin
                    pc_en        = 1'b1;
                    pc_sel       = 1'b1;
                    w_next_state = RUN;
                    if (pc_sel_ex) begin
                        pc_target = pc_ex;
                    end
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State and pending-redirect target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_redirect_q <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            if (w_load_rq) begin
                r_redirect_q <= pc_ex;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_wait_inc),
        .count (wait_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl: a vector table walked
//               from RUN plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        pc_sel_ex;
    logic [31:0] pc_ex;
    logic        stall_dec;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_en;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        if_en;
    logic        if_flush;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] wait_cnt;

    int n_pass;
    int n_total;

    // {imem_req, pc_en, pc_sel, if_en, if_flush}
    localparam logic [4:0] C_NORM  = 5'b11010;
    localparam logic [4:0] C_REDIR = 5'b11111;
    localparam logic [4:0] C_BUBL  = 5'b10011;
    localparam logic [4:0] C_STALL = 5'b10000;
    localparam logic [4:0] C_IDLE  = 5'b00011;

    typedef struct {
        logic        sel;
        logic [31:0] pcx;
        logic        stall;
        logic        ready;
        logic [4:0]  exp_ctl;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[13];

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_sel_ex  (pc_sel_ex),
        .pc_ex      (pc_ex),
        .stall_dec  (stall_dec),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .pc_target  (pc_target),
        .if_en      (if_en),
        .if_flush   (if_flush),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .wait_cnt   (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] p, input logic st, input logic r);
        pc_sel_ex  = s;
        pc_ex      = p;
        stall_dec  = st;
        imem_ready = r;
    endtask

    // Sample Mealy outputs at the falling edge, mid-cycle
    task automatic expect_out(input string name, input logic [4:0] ctl, input logic [31:0] tgt);
        @(negedge clk);
        chk({name, "_ctl"}, {27'd0, imem_req, pc_en, pc_sel, if_en, if_flush}, {27'd0, ctl});
        chk({name, "_tgt"}, pc_target, tgt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name, input logic [15:0] s, input logic [15:0] f,
                           input logic [15:0] w);
        chk({name, "_stall_cnt"}, {16'd0, stall_cnt}, {16'd0, s});
        chk({name, "_flush_cnt"}, {16'd0, flush_cnt}, {16'd0, f});
        chk({name, "_wait_cnt"},  {16'd0, wait_cnt},  {16'd0, w});
    endtask

    // Reset for two edges, then leave the bench in RUN at posedge+1
    task automatic do_reset(input string name);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        expect_out({name, "_in_rst"}, C_IDLE, 32'h0);
        tick();
        rst = 1'b0;
        chk_cnt({name, "_rst"}, 16'd0, 16'd0, 16'd0);
        expect_out({name, "_idle"}, C_IDLE, 32'h0);
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        //            sel   pc_ex         stall ready ctl      target
        vecs[0]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, C_NORM,  32'h0000_0000};
        vecs[1]  = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, C_REDIR, 32'h0000_0100};
        vecs[2]  = '{1'b0, 32'h0000_0100, 1'b0, 1'b1, C_NORM,  32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, C_STALL, 32'h0000_0000};
        vecs[4]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, C_STALL, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, C_STALL, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h0000_0140, 1'b1, 1'b1, C_REDIR, 32'h0000_0140};
        vecs[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, C_BUBL,  32'h0000_0000};
        vecs[8]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, C_STALL, 32'h0000_0000};
        vecs[9]  = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, C_BUBL,  32'h0000_0000};
        vecs[10] = '{1'b1, 32'h0000_0300, 1'b0, 1'b0, C_BUBL,  32'h0000_0200};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, C_REDIR, 32'h0000_0300};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, C_NORM,  32'h0000_0300};

        do_reset("init");

        // Table walk starting in RUN
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].sel, vecs[i].pcx, vecs[i].stall, vecs[i].ready);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_tgt);
            if (i == 1) begin
                tick();
                chk("vec1_flush_cnt", {16'd0, flush_cnt}, 32'd1);
            end else if (i == 5) begin
                tick();
                chk("vec5_stall_cnt", {16'd0, stall_cnt}, 32'd3);
            end else if (i == 6) begin
                tick();
                chk("vec6_stall_cnt", {16'd0, stall_cnt}, 32'd3);
            end else begin
                tick();
            end
        end
        chk_cnt("table_end", 16'd4, 16'd4, 16'd4);

        // Redirect during a miss, a newer redirect in DISCARD, then ready
        do_reset("disc");
        drive(1'b1, 32'h0000_0200, 1'b0, 1'b0);
        expect_out("disc_enter", C_BUBL, 32'h0000_0000);
        tick();
        drive(1'b1, 32'h0000_0300, 1'b0, 1'b0);
        expect_out("disc_latest", C_BUBL, 32'h0000_0200);
        tick();
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
        expect_out("disc_ready", C_REDIR, 32'h0000_0300);
        tick();
        chk_cnt("disc", 16'd0, 16'd2, 16'd2);

        // DISCARD with a new redirect on the ready cycle uses pc_ex directly
        drive(1'b1, 32'h0000_0400, 1'b0, 1'b0);
        expect_out("disc2_enter", C_BUBL, 32'h0000_0300);
        tick();
        drive(1'b1, 32'h0000_0500, 1'b0, 1'b1);
        expect_out("disc2_bypass", C_REDIR, 32'h0000_0500);
        tick();
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
        expect_out("disc2_run", C_NORM, 32'h0000_0500);
        tick();
        chk_cnt("disc2", 16'd0, 16'd4, 16'd3);

        // Reset asserted while in DISCARD
        drive(1'b1, 32'h0000_0600, 1'b0, 1'b0);
        expect_out("rstd_enter", C_BUBL, 32'h0000_0500);
        tick();
        rst = 1'b1;
        drive(1'b1, 32'h0000_0700, 1'b1, 1'b1);
        expect_out("rstd_in_rst", C_IDLE, 32'h0000_0000);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b1);
        chk_cnt("rstd", 16'd0, 16'd0, 16'd0);
        expect_out("rstd_idle", C_IDLE, 32'h0000_0000);
        tick();
        expect_out("rstd_run", C_NORM, 32'h0000_0000);
        tick();

        // Ten clean fetch cycles leave every counter at zero
        for (int i = 0; i < 10; i++) begin
            expect_out($sformatf("clean%0d", i), C_NORM, 32'h0000_0000);
            tick();
        end
        chk_cnt("clean", 16'd0, 16'd0, 16'd0);

        // Long imem wait: the wait counter must stop at all-ones
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_wait_cnt", {16'd0, wait_cnt}, 32'h0000_FFFF);
        chk("sat_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        expect_out("sat_bubble", C_BUBL, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the IF stage of the RV32IM pipeline. It drives the PC register enable, the PC mux select/target, and the IF/ID register enable/flush, arbitrating among EX-stage redirects, decode load-use stalls and a variable-latency instruction memory. It sits beside the PC / pc_mux / pc_adder / imem / fetch_reg datapath and owns no datapath registers except a pending-redirect target and three performance counters.

## Interface
- RESET_PC, 32'h0000_0000, value presented on pc_target while no redirect is active
- CNT_W, 16, width of each saturating performance counter
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_sel_ex  in  1  EX stage requests a redirect (taken branch/jump)
- pc_ex  in  32  redirect target from EX
- stall_dec  in  1  decode load-use stall request
- imem_ready  in  1  instruction memory returns a valid instruction for the current PC this cycle
- imem_req  out  1  fetch request to imem for the current PC
- pc_en  out  1  PC register load enable
- pc_sel  out  1  pc_mux select: 0 = pc_next (PC+4), 1 = pc_target
- pc_target  out  32  redirect target fed to pc_mux
- if_en  out  1  IF/ID register load enable
- if_flush  out  1  IF/ID loads NOP (32'h0000_0013) instead of imem output when if_en=1
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W  saturating counters: decode-stall cycles, redirects taken, imem wait cycles

## Operation
- States: IDLE, RUN, DISCARD. rst (any state, mid-operation included) → IDLE at next edge; redirect_q cleared to RESET_PC, all counters cleared.
- IDLE (one cycle): imem_req=0, pc_en=0, pc_sel=0, if_en=1, if_flush=1, pc_target=RESET_PC. Always → RUN.
- RUN: imem_req=1. Priority redirect > stall > miss > normal:
  - pc_sel_ex=1 and imem_ready=1: pc_en=1, pc_sel=1, pc_target=pc_ex, if_en=1, if_flush=1; flush_cnt++. Stay RUN.
  - pc_sel_ex=1 and imem_ready=0: pc_en=0, if_en=1, if_flush=1; redirect_q←pc_ex; flush_cnt++; → DISCARD.
  - stall_dec=1: pc_en=0, if_en=0 (IF/ID holds); stall_cnt++. Also wait_cnt++ if imem_ready=0.
  - imem_ready=0: pc_en=0, if_en=1, if_flush=1 (bubble); wait_cnt++.
  - otherwise: pc_en=1, pc_sel=0, if_en=1, if_flush=0.
- DISCARD: in-flight fetch is for a wrong-path PC. imem_req=1, if_en=1, if_flush=1, pc_target=redirect_q.
  - New pc_sel_ex=1: redirect_q←pc_ex (latest wins); flush_cnt++; no state change; if imem_ready=1 the same cycle, pc_target=pc_ex is used directly.
  - imem_ready=1: pc_en=1, pc_sel=1; → RUN. stall_dec ignored (decode receives NOP).
  - imem_ready=0: pc_en=0; wait_cnt++.
- Counters saturate at all-ones; no wrap.
- pc_target outside redirect cycles: redirect_q (don't-care for the mux since pc_sel=0).

## Timing
- Outputs imem_req/pc_en/pc_sel/pc_target/if_en/if_flush are Mealy (combinational from state + inputs); counters and redirect_q registered.
- Redirect with imem_ready=1 in RUN: PC = pc_ex after the same rising edge; first correct-path instruction reaches IF/ID one edge later; exactly one NOP inserted.
- Reset values: state IDLE, counters 0, redirect_q RESET_PC; during rst=1 outputs follow IDLE decode.
- Simultaneous pc_sel_ex and stall_dec: redirect wins, stall_cnt not incremented.
- No combinational path from imem_ready to imem_req.

## Structure
- Package fetch_ctrl_pkg: state enum (IDLE=2'd0, RUN=2'd1, DISCARD=2'd2), NOP_INSTR constant 32'h0000_0013.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count), instantiated three times.

## Test plan
- Reset then imem_ready=1 constant, no stalls → pc_en=1 every RUN cycle, if_flush=0, all counters 0 after 10 cycles.
- RUN, pc_sel_ex=1, pc_ex=32'h0000_0100, imem_ready=1 → pc_sel=1, pc_target=0x100, if_flush=1 that cycle; flush_cnt=1; next cycle pc_sel=0.
- stall_dec=1 for 3 cycles → pc_en=0, if_en=0 each cycle; stall_cnt=3; pc_sel_ex=1 during a stall cycle → redirect taken, stall_cnt unchanged.
- pc_sel_ex=1, pc_ex=0x200 with imem_ready=0, then 0x300 next cycle, ready on third → DISCARD entered, pc_target=0x300 with pc_en=1 on ready cycle, flush_cnt=2, wait_cnt=2.
- Hold imem_ready=0 for 70000 cycles → wait_cnt saturates at 16'hFFFF.
- Assert rst while in DISCARD → next cycle IDLE, counters 0, pc_target=RESET_PC, no pending redirect applied after release.
